// File: rtl/spi_minion_param_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_minion_param_if
// Description : SPI pin bundle plus push/pull message handshake for
//               spi_minion_param.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_minion_param_if #(
    parameter int nbits = 8
);
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             pull_en;
    logic [nbits-1:0] pull_msg;
    logic             push_en;
    logic [nbits-1:0] push_msg;
    logic             frame_err;
    logic             busy;

    modport slave (
        input  cs, sclk, mosi, pull_msg,
        output miso, pull_en, push_en, push_msg, frame_err, busy
    );

    modport master (
        output cs, sclk, mosi, pull_msg,
        input  miso, pull_en, push_en, push_msg, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_minion_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_minion_param
// Description : Parametrised SPI minion (width, CPOL/CPHA, bit order) with
//               back-to-back words per cs window and frame-error detection.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_minion_param #(
    parameter int nbits     = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    spi_minion_param_if.slave bus
);
    localparam int         c_cnt_w  = $clog2(nbits + 1);
    localparam logic [0:0] c_idle   = 1'b0;
    localparam logic [0:0] c_active = 1'b1;

    // Two metastability flops per pin, third flop only for edge detection
    logic r_cs_m, r_cs_s, r_cs_d;
    logic r_sclk_m, r_sclk_s, r_sclk_d;
    logic r_mosi_m, r_mosi_s;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [nbits-1:0]   r_tx;
    logic [nbits-1:0]   r_rx;
    logic [nbits-1:0]   r_push_msg;
    logic [c_cnt_w-1:0] r_bitcnt;
    logic               r_skip;
    logic               r_push;

    logic               w_cs_fall, w_cs_rise;
    logic               w_sclk_rise, w_sclk_fall;
    logic               w_lead, w_trail, w_edge_ok;
    logic               w_sample, w_shift;
    logic               w_cs_start, w_cs_stop;
    logic               w_busy, w_pull, w_frame_err;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_word_done;
    logic [nbits-1:0]   w_rx_next;
    logic [nbits-1:0]   w_tx_shifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_m   <= 1'b1;
            r_cs_s   <= 1'b1;
            r_cs_d   <= 1'b1;
            r_sclk_m <= CPOL;
            r_sclk_s <= CPOL;
            r_sclk_d <= CPOL;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
        end else begin
            r_cs_m   <= bus.cs;
            r_cs_s   <= r_cs_m;
            r_cs_d   <= r_cs_s;
            r_sclk_m <= bus.sclk;
            r_sclk_s <= r_sclk_m;
            r_sclk_d <= r_sclk_s;
            r_mosi_m <= bus.mosi;
            r_mosi_s <= r_mosi_m;
        end
    end

    assign w_cs_fall   =  r_cs_d & ~r_cs_s;
    assign w_cs_rise   = ~r_cs_d &  r_cs_s;
    assign w_sclk_rise = ~r_sclk_d &  r_sclk_s;
    assign w_sclk_fall =  r_sclk_d & ~r_sclk_s;
    assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;

    // A cs rise in the same cycle as an sclk edge suppresses the edge
    assign w_edge_ok   = (r_state == c_active) && !w_cs_rise;
    assign w_sample    = w_edge_ok && (CPHA ? w_trail : w_lead);
    assign w_shift     = w_edge_ok && (CPHA ? w_lead : w_trail);

    assign w_cnt_inc    = r_bitcnt + c_cnt_w'(1);
    assign w_word_done  = (w_cnt_inc == c_cnt_w'(nbits));
    assign w_rx_next    = LSB_FIRST ? {r_mosi_s, r_rx[nbits-1:1]} : {r_rx[nbits-2:0], r_mosi_s};
    assign w_tx_shifted = LSB_FIRST ? {1'b0, r_tx[nbits-1:1]} : {r_tx[nbits-2:0], 1'b0};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:   if (w_cs_fall) w_state_next = c_active;
            c_active: if (w_cs_rise) w_state_next = c_idle;
            default:  w_state_next = c_idle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_cs_start = 1'b0;
        w_cs_stop  = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            c_idle:   w_cs_start = w_cs_fall;
            c_active: begin
                w_cs_stop = w_cs_rise;
                w_busy    = 1'b1;
            end
            default:  w_busy = 1'b0;
        endcase
        w_pull      = w_cs_start | r_push;
        w_frame_err = w_cs_stop & (r_bitcnt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_push_msg <= '0;
            r_bitcnt   <= '0;
            r_skip     <= 1'b0;
            r_push     <= 1'b0;
        end else begin
            r_push <= 1'b0;

            // Transmit side: a word reload always honours the pull pulse
            if (w_cs_start) begin
                r_tx   <= bus.pull_msg;
                r_skip <= CPHA;
            end else if (r_push) begin
                r_tx   <= bus.pull_msg;
                r_skip <= ~w_cs_stop;
            end else if (w_cs_stop) begin
                r_skip <= 1'b0;
            end else if (w_shift) begin
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else begin
                    r_tx <= w_tx_shifted;
                end
            end

            // Receive side
            if (w_cs_start) begin
                r_bitcnt <= '0;
            end else if (w_cs_stop) begin
                r_bitcnt <= '0;
                r_rx     <= '0;
            end else if (w_sample) begin
                r_rx <= w_rx_next;
                if (w_word_done) begin
                    r_push     <= 1'b1;
                    r_push_msg <= w_rx_next;
                    r_bitcnt   <= '0;
                end else begin
                    r_bitcnt <= w_cnt_inc;
                end
            end
        end
    end

    assign bus.miso      = LSB_FIRST ? r_tx[0] : r_tx[nbits-1];
    assign bus.pull_en   = w_pull;
    assign bus.push_en   = r_push;
    assign bus.push_msg  = r_push_msg;
    assign bus.frame_err = w_frame_err;
    assign bus.busy      = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_spi_minion_param.sv
`default_nettype none
// Bench for spi_minion_param: four configurations driven by a host model;
// miso bits, pushes, pulls and frame errors are predicted from word streams.
module tb_spi_minion_param;
    localparam int c_ndut = 4;
    localparam int c_half = 6;

    function automatic int cfg_nbits(input int g);
        return (g == 2) ? 12 : ((g == 3) ? 5 : 8);
    endfunction
    function automatic bit cfg_cpol(input int g);
        return (g == 1);
    endfunction
    function automatic bit cfg_cpha(input int g);
        return (g == 1) || (g == 3);
    endfunction
    function automatic bit cfg_lsb(input int g);
        return (g == 2);
    endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cs_p      [c_ndut];
    logic        sclk_p    [c_ndut];
    logic        mosi_p    [c_ndut];
    logic [11:0] pull_tab  [c_ndut][64];
    logic [5:0]  pull_cnt  [c_ndut] = '{default: '0};
    logic        pull_pend [c_ndut] = '{default: 1'b0};
    logic [11:0] push_log  [c_ndut][64];
    logic [5:0]  push_cnt  [c_ndut] = '{default: '0};
    int          ferr_cnt  [c_ndut] = '{default: 0};

    logic        miso_o      [c_ndut];
    logic        pull_en_o   [c_ndut];
    logic        push_en_o   [c_ndut];
    logic        frame_err_o [c_ndut];
    logic        busy_o      [c_ndut];
    logic [11:0] push_msg_o  [c_ndut];

    logic [11:0] host_w [16];
    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < c_ndut; g++) begin : g_dut
        localparam int c_nb = cfg_nbits(g);
        spi_minion_param_if #(.nbits(c_nb)) bus ();
        spi_minion_param #(
            .nbits     (c_nb),
            .CPOL      (cfg_cpol(g)),
            .CPHA      (cfg_cpha(g)),
            .LSB_FIRST (cfg_lsb(g))
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
        assign bus.cs          = cs_p[g];
        assign bus.sclk        = sclk_p[g];
        assign bus.mosi        = mosi_p[g];
        assign bus.pull_msg    = pull_tab[g][pull_cnt[g]][c_nb-1:0];
        assign miso_o[g]       = bus.miso;
        assign pull_en_o[g]    = bus.pull_en;
        assign push_en_o[g]    = bus.push_en;
        assign frame_err_o[g]  = bus.frame_err;
        assign busy_o[g]       = bus.busy;
        assign push_msg_o[g]   = 12'(bus.push_msg);
    end

    // Pull index advances the cycle after a pull pulse so the captured word is stable
    always @(negedge clk) begin
        for (int g = 0; g < c_ndut; g++) begin
            if (pull_pend[g]) pull_cnt[g] <= pull_cnt[g] + 6'd1;
            pull_pend[g] <= pull_en_o[g];
            if (push_en_o[g]) begin
                push_log[g][push_cnt[g]] <= push_msg_o[g];
                push_cnt[g] <= push_cnt[g] + 6'd1;
            end
            if (frame_err_o[g]) ferr_cnt[g] <= ferr_cnt[g] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pull(input int g, input int i, input logic [11:0] v);
        pull_tab[g][pull_cnt[g] + 6'(i)] = v;
    endtask

    task automatic fill_rand(input int g, input int nw);
        logic [11:0] mask;
        mask = 12'((1 << cfg_nbits(g)) - 1);
        for (int i = 0; i <= nw + 1; i++) begin
            set_pull(g, i, 12'($urandom) & mask);
            host_w[i] = 12'($urandom) & mask;
        end
    endtask

    task automatic frame(input int g, input int nbit_total, input int abort_at);
        int nb, nw, f0;
        bit cpol, cpha, lsb;
        logic [5:0]  c0, p0;
        logic [11:0] pw, hw;
        logic        ebit, mbit;
        nb = cfg_nbits(g);
        cpol = cfg_cpol(g);
        cpha = cfg_cpha(g);
        lsb = cfg_lsb(g);
        nw = nbit_total / nb;
        c0 = pull_cnt[g];
        p0 = push_cnt[g];
        f0 = ferr_cnt[g];
        @(negedge clk);
        cs_p[g] = 1'b0;
        if (cpha) repeat (c_half) @(negedge clk);
        for (int j = 0; j < nbit_total; j++) begin
            if (j == abort_at) begin
                cs_p[g] = 1'b1;
                sclk_p[g] = cpol;
                mosi_p[g] = 1'b0;
                reset = 1'b1;
                repeat (3) @(negedge clk);
                check($sformatf("rst miso g%0d", g), 32'(miso_o[g]), 0);
                check($sformatf("rst busy g%0d", g), 32'(busy_o[g]), 0);
                check($sformatf("rst push_msg g%0d", g), 32'(push_msg_o[g]), 0);
                check($sformatf("rst pulses g%0d", g),
                      32'({push_en_o[g], pull_en_o[g], frame_err_o[g]}), 0);
                reset = 1'b0;
                repeat (2 * c_half) @(negedge clk);
                check($sformatf("rst no push g%0d", g), 32'(6'(push_cnt[g] - p0)), 0);
                check($sformatf("rst no ferr g%0d", g), 32'(ferr_cnt[g] - f0), 0);
                return;
            end
            pw = pull_tab[g][c0 + 6'(j / nb)];
            hw = host_w[j / nb];
            ebit = lsb ? pw[j % nb] : pw[nb - 1 - (j % nb)];
            mbit = lsb ? hw[j % nb] : hw[nb - 1 - (j % nb)];
            if (!cpha) begin
                mosi_p[g] = mbit;
                repeat (c_half) @(negedge clk);
                check($sformatf("miso g%0d bit%0d", g, j), 32'(miso_o[g]), 32'(ebit));
                sclk_p[g] = ~cpol;
                repeat (c_half) @(negedge clk);
                sclk_p[g] = cpol;
            end else begin
                sclk_p[g] = ~cpol;
                mosi_p[g] = mbit;
                repeat (c_half) @(negedge clk);
                check($sformatf("miso g%0d bit%0d", g, j), 32'(miso_o[g]), 32'(ebit));
                sclk_p[g] = cpol;
                repeat (c_half) @(negedge clk);
            end
        end
        repeat (c_half) @(negedge clk);
        check($sformatf("busy g%0d", g), 32'(busy_o[g]), 1);
        cs_p[g] = 1'b1;
        repeat (3 * c_half) @(negedge clk);
        check($sformatf("idle g%0d", g), 32'(busy_o[g]), 0);
        check($sformatf("push count g%0d", g), 32'(6'(push_cnt[g] - p0)), 32'(nw));
        check($sformatf("pull count g%0d", g), 32'(6'(pull_cnt[g] - c0)), 32'(nw + 1));
        check($sformatf("frame_err g%0d", g), 32'(ferr_cnt[g] - f0),
              32'((nbit_total % nb) != 0));
        for (int i = 0; i < nw; i++)
            check($sformatf("push word g%0d w%0d", g, i),
                  32'(push_log[g][p0 + 6'(i)]), 32'(host_w[i]));
        if (nw > 0)
            check($sformatf("push_msg hold g%0d", g), 32'(push_msg_o[g]), 32'(host_w[nw - 1]));
    endtask

    initial begin
        int g, nb, nw, part;
        reset = 1'b1;
        for (int k = 0; k < c_ndut; k++) begin
            cs_p[k] = 1'b1;
            sclk_p[k] = cfg_cpol(k);
            mosi_p[k] = 1'b0;
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < c_ndut; k++) begin
            check($sformatf("reset miso g%0d", k), 32'(miso_o[k]), 0);
            check($sformatf("reset busy g%0d", k), 32'(busy_o[k]), 0);
            check($sformatf("reset push_msg g%0d", k), 32'(push_msg_o[k]), 0);
            check($sformatf("reset pulses g%0d", k),
                  32'({push_en_o[k], pull_en_o[k], frame_err_o[k]}), 0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0 and mode 3: pull A5, host sends 3C
        for (int k = 0; k < 2; k++) begin
            set_pull(k, 0, 12'hA5);
            set_pull(k, 1, 12'h00);
            host_w[0] = 12'h3C;
            frame(k, 8, -1);
        end

        // Two back-to-back words in one cs window
        set_pull(0, 0, 12'h81);
        set_pull(0, 1, 12'h7E);
        set_pull(0, 2, 12'h00);
        host_w[0] = 12'hF0;
        host_w[1] = 12'h0F;
        frame(0, 16, -1);

        // 12-bit LSB-first
        fill_rand(2, 1);
        host_w[0] = 12'hABC;
        frame(2, 12, -1);

        // Partial word then a clean frame
        fill_rand(0, 1);
        frame(0, 5, -1);
        fill_rand(0, 1);
        frame(0, 8, -1);

        // Reset mid-word then a clean frame
        fill_rand(0, 1);
        frame(0, 8, 4);
        fill_rand(0, 1);
        frame(0, 8, -1);

        // Randomized frames across all configurations
        for (int r = 0; r < 16; r++) begin
            g = int'($urandom_range(0, c_ndut - 1));
            nb = cfg_nbits(g);
            nw = int'($urandom_range(1, 3));
            part = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nb - 1)) : 0;
            fill_rand(g, nw);
            frame(g, nw * nb + part, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
